// File: rtl/cv32e40p_xmem_responder.sv
// Xmem responder: runs one Xmem request at a time on the OBI data port and returns an Xmem response.
// Latency is accept+3 cycles with zero-wait gnt/rvalid and accept+1 for illegal requests; the response holds until p_ready.
package cv32e40p_xmem_pkg;
    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_req_type_e;
endpackage

module cv32e40p_xmem_responder
    import cv32e40p_xmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int RANGE_WIDTH = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   xmem_q_valid_i,
    output logic                   xmem_q_ready_o,
    input  logic [ADDR_WIDTH-1:0]  xmem_q_laddr_i,
    input  logic [31:0]            xmem_q_wdata_i,
    input  logic [2:0]             xmem_q_width_i,
    input  mem_req_type_e          xmem_q_req_type_i,
    input  logic                   xmem_q_mode_i,
    input  logic                   xmem_q_spec_i,
    input  logic                   xmem_q_endoftransaction_i,

    output logic                   xmem_p_valid_o,
    input  logic                   xmem_p_ready_i,
    output logic [31:0]            xmem_p_rdata_o,
    output logic [RANGE_WIDTH-1:0] xmem_p_range_o,
    output logic                   xmem_p_status_o,

    output logic                   data_req_o,
    input  logic                   data_gnt_i,
    output logic [ADDR_WIDTH-1:0]  data_addr_o,
    output logic                   data_we_o,
    output logic [3:0]             data_be_o,
    output logic [31:0]            data_wdata_o,
    input  logic                   data_rvalid_i,
    input  logic                   data_err_i,
    input  logic [31:0]            data_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

    localparam logic [RANGE_WIDTH-1:0] RANGE_MAX = {RANGE_WIDTH{1'b1}};
    localparam logic [RANGE_WIDTH-1:0] RANGE_ONE = {{(RANGE_WIDTH-1){1'b0}}, 1'b1};

    state_e                  r_state;
    logic                    r_q_ready;
    logic                    r_p_valid;
    logic [31:0]             r_rdata;
    logic                    r_status;
    logic [RANGE_WIDTH-1:0]  r_range;
    logic                    r_data_req;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_we;
    logic [3:0]              r_be;
    logic [31:0]             r_wdata;
    logic [2:0]              r_width;
    logic [1:0]              r_lsb;
    logic                    r_eot;
    logic                    r_unused_mode;

    logic                    w_accept;
    logic                    w_illegal;
    logic [1:0]              w_lsb;
    logic [3:0]              w_be;
    logic [31:0]             w_shifted;
    logic [31:0]             w_rdata_masked;
    logic                    w_p_handshake;

    assign w_accept      = xmem_q_valid_i && r_q_ready;
    assign w_lsb         = xmem_q_laddr_i[1:0];
    assign w_p_handshake = r_p_valid && xmem_p_ready_i;

    // Misaligned half/word, unknown widths and speculative writes never reach the bus.
    assign w_illegal = (xmem_q_width_i > 3'd2)
                    || ((xmem_q_width_i == 3'd1) && w_lsb[0])
                    || ((xmem_q_width_i == 3'd2) && (w_lsb != 2'b00))
                    || ((xmem_q_req_type_i == MEM_WRITE) && xmem_q_spec_i);

    always_comb begin
        w_be = 4'b1111;
        case (xmem_q_width_i)
            3'd0:    w_be = 4'b0001 << w_lsb;
            3'd1:    w_be = 4'b0011 << w_lsb;
            default: w_be = 4'b1111;
        endcase
    end

    assign w_shifted = data_rdata_i >> {r_lsb, 3'b000};

    always_comb begin
        w_rdata_masked = w_shifted;
        case (r_width)
            3'd0:    w_rdata_masked = {24'h0, w_shifted[7:0]};
            3'd1:    w_rdata_masked = {16'h0, w_shifted[15:0]};
            default: w_rdata_masked = w_shifted;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_q_ready     <= 1'b1;
            r_p_valid     <= 1'b0;
            r_rdata       <= 32'h0;
            r_status      <= 1'b0;
            r_range       <= '0;
            r_data_req    <= 1'b0;
            r_addr        <= '0;
            r_we          <= 1'b0;
            r_be          <= 4'h0;
            r_wdata       <= 32'h0;
            r_width       <= 3'd0;
            r_lsb         <= 2'd0;
            r_eot         <= 1'b0;
            r_unused_mode <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_q_ready     <= 1'b0;
                        r_width       <= xmem_q_width_i;
                        r_lsb         <= w_lsb;
                        r_eot         <= xmem_q_endoftransaction_i;
                        r_unused_mode <= xmem_q_mode_i;
                        if (w_illegal) begin
                            r_rdata   <= 32'h0;
                            r_status  <= 1'b1;
                            r_p_valid <= 1'b1;
                            r_state   <= ST_RSP;
                        end else begin
                            r_addr     <= {xmem_q_laddr_i[ADDR_WIDTH-1:2], 2'b00};
                            r_we       <= (xmem_q_req_type_i == MEM_WRITE);
                            r_be       <= w_be;
                            r_wdata    <= xmem_q_wdata_i << {w_lsb, 3'b000};
                            r_data_req <= 1'b1;
                            r_state    <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (data_gnt_i) begin
                        r_data_req <= 1'b0;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (data_rvalid_i) begin
                        r_status  <= data_err_i;
                        r_rdata   <= r_we ? 32'h0 : w_rdata_masked;
                        r_p_valid <= 1'b1;
                        r_state   <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (w_p_handshake) begin
                        r_p_valid <= 1'b0;
                        r_q_ready <= 1'b1;
                        r_state   <= ST_IDLE;
                        // A sequence ends on eot or on the first error.
                        if (r_eot || r_status) begin
                            r_range <= '0;
                        end else if (r_range != RANGE_MAX) begin
                            r_range <= r_range + RANGE_ONE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign xmem_q_ready_o  = r_q_ready;
    assign xmem_p_valid_o  = r_p_valid;
    assign xmem_p_rdata_o  = r_rdata;
    assign xmem_p_range_o  = r_range;
    assign xmem_p_status_o = r_status;
    assign data_req_o      = r_data_req;
    assign data_addr_o     = r_addr;
    assign data_we_o       = r_we;
    assign data_be_o       = r_be;
    assign data_wdata_o    = r_wdata;

endmodule

// File: tb/tb_cv32e40p_xmem_responder.sv
// Directed bench for cv32e40p_xmem_responder: hand-computed vectors checked with immediate assertions.
module tb_cv32e40p_xmem_responder;
    import cv32e40p_xmem_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          q_valid = 1'b0;
    logic          q_ready;
    logic [31:0]   q_laddr = 32'h0;
    logic [31:0]   q_wdata = 32'h0;
    logic [2:0]    q_width = 3'd0;
    mem_req_type_e q_type = MEM_READ;
    logic          q_mode = 1'b0;
    logic          q_spec = 1'b0;
    logic          q_eot = 1'b0;
    logic          p_valid;
    logic          p_ready = 1'b0;
    logic [31:0]   p_rdata;
    logic [4:0]    p_range;
    logic          p_status;
    logic          d_req;
    logic          d_gnt = 1'b0;
    logic [31:0]   d_addr;
    logic          d_we;
    logic [3:0]    d_be;
    logic [31:0]   d_wdata;
    logic          d_rvalid = 1'b0;
    logic          d_err = 1'b0;
    logic [31:0]   d_rdata = 32'h0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cv32e40p_xmem_responder #(.ADDR_WIDTH(32), .RANGE_WIDTH(5)) dut (
        .clk_i                     (clk),
        .rst_i                     (rst),
        .xmem_q_valid_i            (q_valid),
        .xmem_q_ready_o            (q_ready),
        .xmem_q_laddr_i            (q_laddr),
        .xmem_q_wdata_i            (q_wdata),
        .xmem_q_width_i            (q_width),
        .xmem_q_req_type_i         (q_type),
        .xmem_q_mode_i             (q_mode),
        .xmem_q_spec_i             (q_spec),
        .xmem_q_endoftransaction_i (q_eot),
        .xmem_p_valid_o            (p_valid),
        .xmem_p_ready_i            (p_ready),
        .xmem_p_rdata_o            (p_rdata),
        .xmem_p_range_o            (p_range),
        .xmem_p_status_o           (p_status),
        .data_req_o                (d_req),
        .data_gnt_i                (d_gnt),
        .data_addr_o               (d_addr),
        .data_we_o                 (d_we),
        .data_be_o                 (d_be),
        .data_wdata_o              (d_wdata),
        .data_rvalid_i             (d_rvalid),
        .data_err_i                (d_err),
        .data_rdata_i              (d_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One complete request/response with optional grant stall and response backpressure.
    task automatic txn(input string tag, input mem_req_type_e typ, input logic [2:0] w,
                       input logic [31:0] a, input logic [31:0] wd, input logic sp,
                       input logic eot, input logic [31:0] brd, input logic berr,
                       input logic ill, input int gnt_wait, input int hold,
                       input logic [31:0] e_addr, input logic [3:0] e_be,
                       input logic [31:0] e_wd, input logic [31:0] e_rd,
                       input logic e_st, input logic [4:0] e_rng);
        chk({tag, ".q_ready_idle"}, {31'h0, q_ready}, 32'h1);
        q_valid = 1'b1; q_type = typ; q_width = w; q_laddr = a;
        q_wdata = wd; q_spec = sp; q_eot = eot; q_mode = 1'b1;
        tick();
        q_valid = 1'b0; q_wdata = 32'hFFFF_FFFF; q_laddr = 32'hFFFF_FFFF;
        chk({tag, ".q_ready_busy"}, {31'h0, q_ready}, 32'h0);
        if (!ill) begin
            for (int i = 0; i <= gnt_wait; i++) begin
                chk({tag, ".req"}, {31'h0, d_req}, 32'h1);
                chk({tag, ".addr"}, d_addr, e_addr);
                chk({tag, ".be"}, {28'h0, d_be}, {28'h0, e_be});
                chk({tag, ".wdata"}, d_wdata, e_wd);
                chk({tag, ".we"}, {31'h0, d_we}, {31'h0, typ == MEM_WRITE});
                if (i < gnt_wait) tick();
            end
            d_gnt = 1'b1;
            tick();
            d_gnt = 1'b0;
            chk({tag, ".req_drop"}, {31'h0, d_req}, 32'h0);
            chk({tag, ".p_valid_wait"}, {31'h0, p_valid}, 32'h0);
            d_rvalid = 1'b1; d_rdata = brd; d_err = berr;
            tick();
            d_rvalid = 1'b0; d_rdata = 32'h0; d_err = 1'b0;
        end else begin
            chk({tag, ".no_req"}, {31'h0, d_req}, 32'h0);
        end
        chk({tag, ".p_valid"}, {31'h0, p_valid}, 32'h1);
        chk({tag, ".rdata"}, p_rdata, e_rd);
        chk({tag, ".status"}, {31'h0, p_status}, {31'h0, e_st});
        chk({tag, ".range"}, {27'h0, p_range}, {27'h0, e_rng});
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, ".hold_valid"}, {31'h0, p_valid}, 32'h1);
            chk({tag, ".hold_rdata"}, p_rdata, e_rd);
            chk({tag, ".hold_q_ready"}, {31'h0, q_ready}, 32'h0);
        end
        p_ready = 1'b1;
        tick();
        p_ready = 1'b0;
        chk({tag, ".p_valid_done"}, {31'h0, p_valid}, 32'h0);
        chk({tag, ".q_ready_done"}, {31'h0, q_ready}, 32'h1);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst.q_ready", {31'h0, q_ready}, 32'h1);
        chk("rst.p_valid", {31'h0, p_valid}, 32'h0);
        chk("rst.req", {31'h0, d_req}, 32'h0);
        chk("rst.addr", d_addr, 32'h0);
        chk("rst.be", {28'h0, d_be}, 32'h0);
        chk("rst.wdata", d_wdata, 32'h0);
        chk("rst.we", {31'h0, d_we}, 32'h0);
        chk("rst.rdata", p_rdata, 32'h0);
        chk("rst.status", {31'h0, p_status}, 32'h0);
        chk("rst.range", {27'h0, p_range}, 32'h0);

        //   tag      type       w     addr          wdata         sp    eot   bus rdata     err   ill  gw hold  e_addr        e_be     e_wdata       e_rdata       st    rng
        txn("t1_rdw", MEM_READ,  3'd2, 32'h0000_1000, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 0, 0, 32'h0000_1000, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0, 5'd0);
        txn("t2_wrb", MEM_WRITE, 3'd0, 32'h0000_1003, 32'h0000_00AB, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 2, 0, 32'h0000_1000, 4'b1000, 32'hAB00_0000, 32'h0,        1'b0, 5'd1);
        txn("t3_ilh", MEM_READ,  3'd1, 32'h0000_1001, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 5'd2);
        txn("t3_ilw", MEM_WRITE, 3'd2, 32'h0000_3000, 32'h1234,     1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 5'd0);
        txn("t4_rdb", MEM_READ,  3'd0, 32'h0000_2002, 32'h0,        1'b0, 1'b1, 32'h11223344, 1'b0, 1'b0, 0, 3, 32'h0000_2000, 4'b0100, 32'h0,        32'h0000_0022, 1'b0, 5'd0);
        txn("t5_a",   MEM_READ,  3'd1, 32'h0000_4002, 32'h0,        1'b0, 1'b0, 32'hCAFE1234, 1'b0, 1'b0, 0, 0, 32'h0000_4000, 4'b1100, 32'h0,        32'h0000_CAFE, 1'b0, 5'd0);
        txn("t5_b",   MEM_READ,  3'd2, 32'h0000_4004, 32'h0,        1'b0, 1'b0, 32'h01020304, 1'b0, 1'b0, 1, 0, 32'h0000_4004, 4'b1111, 32'h0,        32'h01020304, 1'b0, 5'd1);
        txn("t5_c",   MEM_READ,  3'd0, 32'h0000_4005, 32'h0,        1'b0, 1'b1, 32'hA5B6C7D8, 1'b0, 1'b0, 0, 0, 32'h0000_4004, 4'b0010, 32'h0,        32'h0000_00C7, 1'b0, 5'd2);
        txn("t5_d",   MEM_READ,  3'd2, 32'h0000_4008, 32'h0,        1'b0, 1'b0, 32'h55AA55AA, 1'b0, 1'b0, 0, 0, 32'h0000_4008, 4'b1111, 32'h0,        32'h55AA55AA, 1'b0, 5'd0);

        q_valid = 1'b1; q_type = MEM_READ; q_width = 3'd2; q_laddr = 32'h0000_6000; q_eot = 1'b0;
        tick();
        q_valid = 1'b0;
        d_gnt = 1'b1;
        tick();
        d_gnt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6.q_ready_rst", {31'h0, q_ready}, 32'h1);
        chk("t6.p_valid_rst", {31'h0, p_valid}, 32'h0);
        chk("t6.req_rst", {31'h0, d_req}, 32'h0);
        chk("t6.range_rst", {27'h0, p_range}, 32'h0);
        d_rvalid = 1'b1; d_rdata = 32'hFFFF_FFFF;
        tick();
        d_rvalid = 1'b0; d_rdata = 32'h0;
        chk("t6.stray_p_valid", {31'h0, p_valid}, 32'h0);
        chk("t6.stray_q_ready", {31'h0, q_ready}, 32'h1);
        tick();
        chk("t6.stray_p_valid2", {31'h0, p_valid}, 32'h0);
        txn("t6_err", MEM_READ,  3'd2, 32'h0000_5000, 32'h0,        1'b0, 1'b0, 32'h12345678, 1'b1, 1'b0, 0, 0, 32'h0000_5000, 4'b1111, 32'h0,        32'h12345678, 1'b1, 5'd0);
        txn("t6_clr", MEM_READ,  3'd0, 32'h0000_5001, 32'h0,        1'b0, 1'b0, 32'h0000AB00, 1'b0, 1'b0, 0, 0, 32'h0000_5000, 4'b0010, 32'h0,        32'h0000_00AB, 1'b0, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
